// File: rtl/seq_div.sv
// Sequential unsigned restoring divider, one quotient bit per clock, MSB first.
// Optional macro SEQ_DIV_ZERO_DETECT_EN: a zero divisor finishes at once and raises div_by_zero.
module seq_div #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIN
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] dvdShift_q, dvdShift_d;
  logic [WIDTH-1:0] divisor_q, divisor_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   remNext;
  logic [WIDTH-1:0] quotNext;
  logic             qBit;
  logic             accept;

  // One restoring step: bring in the next dividend bit, subtract if it fits.
  // The partial remainder is WIDTH+1 bits so the shifted value never overflows.
  always_comb begin
    shifted  = (rem_q << 1) | {{WIDTH{1'b0}}, dvdShift_q[WIDTH-1]};
    qBit     = (shifted >= {1'b0, divisor_q});
    remNext  = qBit ? (shifted - {1'b0, divisor_q}) : shifted;
    quotNext = (quot_q << 1) | {{(WIDTH-1){1'b0}}, qBit};
  end

  assign accept = start && ((state_q == IDLE) || (state_q == FIN));

  always_comb begin
    state_d     = state_q;
    dvdShift_d  = dvdShift_q;
    divisor_d   = divisor_q;
    quot_d      = quot_q;
    rem_d       = rem_q;
    count_d     = count_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;

    case (state_q)
      CALC: begin
        dvdShift_d = dvdShift_q << 1;
        rem_d      = remNext;
        quot_d     = quotNext;
        count_d    = count_q - CW'(1);
        if (count_q == CW'(1)) begin
          state_d     = FIN;
          quotient_d  = quotNext;
          remainder_d = remNext[WIDTH-1:0];
          dbz_d       = 1'b0;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Start is honoured from IDLE and FIN alike, which gives back-to-back operation.
    if (accept) begin
      state_d    = CALC;
      dvdShift_d = dividend;
      divisor_d  = divisor;
      quot_d     = '0;
      rem_d      = '0;
      count_d    = CW'(WIDTH);
`ifdef SEQ_DIV_ZERO_DETECT_EN
      if (divisor == '0) begin
        state_d     = FIN;
        quotient_d  = '1;
        remainder_d = dividend;
        dbz_d       = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      dvdShift_q  <= '0;
      divisor_q   <= '0;
      quot_q      <= '0;
      rem_q       <= '0;
      count_q     <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      dvdShift_q  <= dvdShift_d;
      divisor_q   <= divisor_d;
      quot_q      <= quot_d;
      rem_q       <= rem_d;
      count_q     <= count_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;
  assign busy        = (state_q == CALC);
  assign done        = (state_q == FIN);

endmodule

// File: tb/tb_seq_div.sv
// Directed self-checking bench for seq_div (WIDTH=8), covering both
// builds of SEQ_DIV_ZERO_DETECT_EN.
module tb_seq_div;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       busy;
  logic       done;
  logic       div_by_zero;

  int checks;
  int passes;
  int edgeCnt;
  int busyCnt;
  int doneCnt;
  int firstEdge;

  seq_div #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .quotient   (quotient),
    .remainder  (remainder),
    .busy       (busy),
    .done       (done),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int unsigned observed, input int unsigned expected);
    checks++;
    if (observed == expected) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic stepEdge();
    @(posedge clk);
    #1;
    edgeCnt++;
  endtask

  task automatic waitDone(input int limit);
    while (!done && edgeCnt < limit) begin
      busyCnt += int'(busy);
      stepEdge();
    end
  endtask

  // Start a division; edgeCnt ends as the edge count (accept edge = 1) at which done rose.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    edgeCnt  = 0;
    busyCnt  = 0;
    stepEdge();
    start = 1'b0;
    waitDone(40);
  endtask

  initial begin
    checks   = 0;
    passes   = 0;
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    #2;
    checkOutput("rst_quotient", quotient, 0);
    checkOutput("rst_remainder", remainder, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_dbz", div_by_zero, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // 100/7 with latency and busy duration
    applyStimulus(8'd100, 8'd7);
    checkOutput("d100_done", done, 1);
    checkOutput("d100_latency", edgeCnt, 9);
    checkOutput("d100_busy_cycles", busyCnt, 8);
    checkOutput("d100_busy_at_done", busy, 0);
    checkOutput("d100_quotient", quotient, 14);
    checkOutput("d100_remainder", remainder, 2);
    checkOutput("d100_dbz", div_by_zero, 0);
    stepEdge();
    checkOutput("d100_done_pulse", done, 0);
    checkOutput("d100_hold_q", quotient, 14);

    applyStimulus(8'd255, 8'd1);
    checkOutput("d255_latency", edgeCnt, 9);
    checkOutput("d255_quotient", quotient, 255);
    checkOutput("d255_remainder", remainder, 0);

    applyStimulus(8'd5, 8'd9);
    checkOutput("d5_latency", edgeCnt, 9);
    checkOutput("d5_quotient", quotient, 0);
    checkOutput("d5_remainder", remainder, 5);

    applyStimulus(8'd200, 8'd200);
    checkOutput("d200_quotient", quotient, 1);
    checkOutput("d200_remainder", remainder, 0);
    stepEdge();

    // Zero divisor
    applyStimulus(8'd77, 8'd0);
    checkOutput("dz_done", done, 1);
    checkOutput("dz_quotient", quotient, 255);
    checkOutput("dz_remainder", remainder, 77);
`ifdef SEQ_DIV_ZERO_DETECT_EN
    checkOutput("dz_latency", edgeCnt, 1);
    checkOutput("dz_busy_cycles", busyCnt, 0);
    checkOutput("dz_dbz", div_by_zero, 1);
`else
    checkOutput("dz_latency", edgeCnt, 9);
    checkOutput("dz_busy_cycles", busyCnt, 8);
    checkOutput("dz_dbz", div_by_zero, 0);
`endif
    stepEdge();

    // Start pulse in the third CALC cycle must be ignored
    dividend = 8'd100;
    divisor  = 8'd7;
    start    = 1'b1;
    edgeCnt  = 0;
    busyCnt  = 0;
    stepEdge();
    start = 1'b0;
    stepEdge();
    stepEdge();
    dividend = 8'd50;
    divisor  = 8'd5;
    start    = 1'b1;
    stepEdge();
    start = 1'b0;
    waitDone(40);
    checkOutput("ign_latency", edgeCnt, 9);
    checkOutput("ign_quotient", quotient, 14);
    checkOutput("ign_remainder", remainder, 2);
    doneCnt = 0;
    for (int i = 0; i < 12; i++) begin
      stepEdge();
      doneCnt += int'(done);
    end
    checkOutput("ign_no_second_done", doneCnt, 0);
    checkOutput("ign_hold_r", remainder, 2);

    // Reset in the fourth CALC cycle
    dividend = 8'd100;
    divisor  = 8'd7;
    start    = 1'b1;
    edgeCnt  = 0;
    stepEdge();
    start = 1'b0;
    stepEdge();
    stepEdge();
    stepEdge();
    #2;
    rst = 1'b1;
    #1;
    checkOutput("arst_quotient", quotient, 0);
    checkOutput("arst_remainder", remainder, 0);
    checkOutput("arst_busy", busy, 0);
    checkOutput("arst_done", done, 0);
    checkOutput("arst_dbz", div_by_zero, 0);
    doneCnt = 0;
    for (int i = 0; i < 10; i++) begin
      stepEdge();
      doneCnt += int'(done);
    end
    checkOutput("arst_no_done", doneCnt, 0);
    rst = 1'b0;
    applyStimulus(8'd9, 8'd2);
    checkOutput("post_rst_latency", edgeCnt, 9);
    checkOutput("post_rst_quotient", quotient, 4);
    checkOutput("post_rst_remainder", remainder, 1);
    stepEdge();

    // Back-to-back with start held through FIN
    dividend = 8'd100;
    divisor  = 8'd7;
    start    = 1'b1;
    edgeCnt  = 0;
    busyCnt  = 0;
    stepEdge();
    waitDone(40);
    checkOutput("b2b_first_latency", edgeCnt, 9);
    checkOutput("b2b_first_quotient", quotient, 14);
    checkOutput("b2b_first_remainder", remainder, 2);
    dividend  = 8'd63;
    divisor   = 8'd8;
    firstEdge = edgeCnt;
    stepEdge();
    start = 1'b0;
    checkOutput("b2b_accepted_busy", busy, 1);
    waitDone(firstEdge + 40);
    checkOutput("b2b_spacing", edgeCnt - firstEdge, 9);
    checkOutput("b2b_second_quotient", quotient, 7);
    checkOutput("b2b_second_remainder", remainder, 7);
    stepEdge();
    checkOutput("b2b_idle_after", done, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
